// File: rtl/dmem_responder_if.sv
// Load/store port between the memory/write-back stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, byte-lane stores,
// sign/zero-extended loads and an error flag on a registered valid/ready response.

// One byte lane of the data memory plus its store steering.
module dmem_lane #(
  parameter int LANE  = 0,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          wr,
  input  logic [1:0]    size,
  input  logic [1:0]    sel,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [7:0]    rbyte
);
  localparam logic [1:0] LN = 2'(LANE);

  logic [7:0] mem [DEPTH];
  logic       hit;
  logic [7:0] wb;

  // Stores are right-aligned, so byte/half data is picked from the low bits.
  always_comb begin
    hit = 1'b0;
    wb  = wdata[8*LANE +: 8];
    case (size)
      2'd0: begin
        hit = (sel == LN);
        wb  = wdata[7:0];
      end
      2'd1: begin
        hit = (sel[1] == LN[1]);
        wb  = LN[0] ? wdata[15:8] : wdata[7:0];
      end
      2'd2: hit = 1'b1;
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk)
    if (wr && hit) mem[idx] <= wb;

  assign rbyte = mem[idx];
endmodule

module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int          NUM_LANES = 4;
  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          ZERO_LAT  = (LATENCY == 0);
  localparam logic [3:0]  CNT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic [1:0]  state;
  logic [3:0]  cnt;
  req_t        inc, cap, cur;
  logic        enter_resp, err, wr;
  logic        rvalid, rerr;
  logic [31:0] rdata;

  logic [NUM_LANES-1:0][7:0] rbyte;
  logic [31:0] rword, ldata;
  logic [7:0]  lb;
  logic [15:0] lh;

  assign inc = {bus.req_we, bus.req_size, bus.req_unsigned, bus.req_addr, bus.req_wdata};

  // With zero latency the response is formed on the acceptance edge, straight from the bus.
  assign cur = (state == S_IDLE) ? inc : cap;

  assign enter_resp = !rst &&
                      ((ZERO_LAT && state == S_IDLE && bus.req_valid) ||
                       (state == S_WAIT && cnt == 4'd0));

  always_comb begin
    err = 1'b0;
    case (cur.size)
      2'd1:    err = cur.addr[0];
      2'd2:    err = |cur.addr[1:0];
      2'd3:    err = 1'b1;
      default: err = 1'b0;
    endcase
    if ({2'b00, cur.addr[31:2]} >= DEPTH_W) err = 1'b1;
  end

  assign wr = enter_resp && cur.we && !err;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dmem_lane #(.LANE(i), .DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk   (clk),
      .wr    (wr),
      .size  (cur.size),
      .sel   (cur.addr[1:0]),
      .idx   (cur.addr[2 +: AW]),
      .wdata (cur.wdata),
      .rbyte (rbyte[i])
    );
  end

  assign rword = rbyte;

  always_comb begin
    lb    = rbyte[cur.addr[1:0]];
    lh    = cur.addr[1] ? rword[31:16] : rword[15:0];
    ldata = rword;
    case (cur.size)
      2'd0:    ldata = {{24{lb[7] & ~cur.uns}}, lb};
      2'd1:    ldata = {{16{lh[15] & ~cur.uns}}, lh};
      default: ldata = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      cap    <= '0;
      rvalid <= 1'b0;
      rdata  <= 32'd0;
      rerr   <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (bus.req_valid) begin
            cap   <= inc;
            cnt   <= CNT_INIT;
            state <= ZERO_LAT ? S_RESP : S_WAIT;
          end
        S_WAIT:
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        S_RESP:
          if (bus.rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (enter_resp) begin
        rvalid <= 1'b1;
        rerr   <= err;
        rdata  <= (err || cur.we) ? 32'd0 : ldata;
      end else if (state == S_RESP && bus.rsp_ready) begin
        rvalid <= 1'b0;
        rerr   <= 1'b0;
        rdata  <= 32'd0;
      end
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = rvalid;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = rerr;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed memory model; covers
// LATENCY=2 and LATENCY=0 builds side by side.
module tb_dmem_responder;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dmem_responder_if b2();
  dmem_responder_if b0();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut  (.clk(clk), .rst(rst), .bus(b2));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  // Byte-addressed reference memory; [0,1024) mirrors dut, [1024,2048) mirrors dut0.
  logic [7:0] mb [0:2047];

  function automatic void model(input int base, input logic we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int n;
    longint v;
    n  = 1 << sz;
    rd = 32'd0;
    er = (sz == 2'd3) || ((a % n) != 0) || ((a / 4) >= DEPTH);
    if (er) return;
    if (we) begin
      for (int k = 0; k < n; k++) mb[base + int'(a) + k] = wd[8*k +: 8];
    end else begin
      v = 0;
      for (int k = 0; k < n; k++) v = v | (longint'(mb[base + int'(a) + k]) << (8*k));
      if (!uns && n < 4 && (((v >> (8*n - 1)) & 1) == 1)) v = v - (longint'(1) << (8*n));
      rd = v[31:0];
    end
  endfunction

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    b2.req_valid = 1'b1; b2.req_we = we; b2.req_size = sz;
    b2.req_unsigned = uns; b2.req_addr = a; b2.req_wdata = wd;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    n = 0;
    while (!b2.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    if (n >= 40) begin
      vec++; bad++;
      $display("FAIL rsp_timeout: no rsp_valid within %0d cycles of addr %h", n, a);
    end
    lat = n + 1;
    rd  = b2.rsp_rdata;
    er  = b2.rsp_err;
    b2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b2.rsp_ready = 1'b0;
  endtask

  task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat,
                     output logic [31:0] erd, output logic eer);
    model(0, we, sz, uns, a, wd, erd, eer);
    xact(we, sz, uns, a, wd, rd, er, lat);
  endtask

  task automatic test_reset;
    b2.req_valid = 0; b2.req_we = 0; b2.req_size = 0; b2.req_unsigned = 0;
    b2.req_addr = 0; b2.req_wdata = 0; b2.rsp_ready = 0;
    b0.req_valid = 0; b0.req_we = 0; b0.req_size = 0; b0.req_unsigned = 0;
    b0.req_addr = 0; b0.req_wdata = 0; b0.rsp_ready = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (b2.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", b2.req_ready); end
    vec++; if (b2.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", b2.rsp_valid); end
    vec++; if (b2.rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 0", b2.rsp_rdata); end
    vec++; if (b2.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", b2.rsp_err); end
    vec++; if ({b0.req_ready, b0.rsp_valid, b0.rsp_err, b0.rsp_rdata} !== {3'b100, 32'd0})
      begin bad++; $display("FAIL reset_lat0: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0",
                            b0.req_ready, b0.rsp_valid, b0.rsp_err, b0.rsp_rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_preload;
    logic [31:0] rd, erd; logic er, eer; int lat;
    for (int w = 0; w < DEPTH; w++) begin
      run(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, rd, er, lat, erd, eer);
      vec++; if ({er, rd} !== {eer, erd})
        begin bad++; $display("FAIL preload_sw: word %0d got err=%b rd=%h want 0 0", w, er, rd); end
    end
  endtask

  task automatic test_word_roundtrip;
    logic [31:0] rd, erd; logic er, eer; int lat;
    run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, erd, eer);
    vec++; if ({er, rd} !== 33'd0) begin bad++; $display("FAIL sw_resp: got err=%b rd=%h want 0 0", er, rd); end
    vec++; if (lat !== 3) begin bad++; $display("FAIL sw_latency: got %0d want 3", lat); end
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, erd, eer);
    vec++; if ({er, rd} !== {1'b0, 32'hDEADBEEF})
      begin bad++; $display("FAIL lw_roundtrip: got err=%b rd=%h want 0 deadbeef", er, rd); end
    vec++; if (lat !== 3) begin bad++; $display("FAIL lw_latency: got %0d want 3", lat); end
  endtask

  typedef struct packed {
    logic we; logic [1:0] sz; logic uns; logic [31:0] a; logic [31:0] wd; logic [31:0] ex;
  } op_t;

  task automatic test_lanes;
    logic [31:0] rd, erd; logic er, eer; int lat;
    op_t t [11] = '{
      '{1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'h00000000},
      '{1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, 32'h00000000},
      '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h11AA3344},
      '{1'b1, 2'd1, 1'b0, 32'h20, 32'h0000BEEF, 32'h00000000},
      '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h11AABEEF},
      '{1'b0, 2'd0, 1'b0, 32'h22, 32'h0,        32'hFFFFFFAA},
      '{1'b0, 2'd0, 1'b1, 32'h22, 32'h0,        32'h000000AA},
      '{1'b0, 2'd1, 1'b0, 32'h20, 32'h0,        32'hFFFFBEEF},
      '{1'b0, 2'd1, 1'b1, 32'h20, 32'h0,        32'h0000BEEF},
      '{1'b0, 2'd0, 1'b0, 32'h23, 32'h0,        32'h00000011},
      '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        32'h000011AA}
    };
    for (int i = 0; i < 11; i++) begin
      run(t[i].we, t[i].sz, t[i].uns, t[i].a, t[i].wd, rd, er, lat, erd, eer);
      vec++; if ({er, rd} !== {1'b0, t[i].ex})
        begin bad++; $display("FAIL lanes_%0d: got err=%b rd=%h want 0 %h", i, er, rd, t[i].ex); end
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd, erd; logic er, eer; int lat;
    op_t t [5] = '{
      '{1'b0, 2'd1, 1'b0, 32'h21,  32'h0,        32'h0},
      '{1'b1, 2'd2, 1'b0, 32'h22,  32'h12345678, 32'h0},
      '{1'b0, 2'd3, 1'b0, 32'h0,   32'h0,        32'h0},
      '{1'b1, 2'd3, 1'b0, 32'h0,   32'hCAFEF00D, 32'h0},
      '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'h0}
    };
    for (int i = 0; i < 5; i++) begin
      run(t[i].we, t[i].sz, t[i].uns, t[i].a, t[i].wd, rd, er, lat, erd, eer);
      vec++; if ({er, rd} !== {1'b1, 32'd0})
        begin bad++; $display("FAIL err_%0d: got err=%b rd=%h want 1 0", i, er, rd); end
    end
    run(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, erd, eer);
    vec++; if ({er, rd} !== {1'b0, 32'h11AABEEF})
      begin bad++; $display("FAIL err_untouched_20: got err=%b rd=%h want 0 11aabeef", er, rd); end
    run(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er, lat, erd, eer);
    vec++; if ({er, rd} !== {eer, erd})
      begin bad++; $display("FAIL err_untouched_0: got err=%b rd=%h want %b %h", er, rd, eer, erd); end
  endtask

  task automatic test_backpressure;
    logic [31:0] ea, eb, held; logic e; int n;
    model(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, ea, e);
    model(0, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, eb, e);
    b2.req_valid = 1'b1; b2.req_we = 1'b0; b2.req_size = 2'd2; b2.req_unsigned = 1'b0;
    b2.req_addr = 32'h40; b2.req_wdata = 32'h0;
    @(posedge clk); #1;
    b2.req_addr = 32'h44;  // second request stays pending on the bus
    n = 0;
    while (!b2.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    vec++; if (n !== 2) begin bad++; $display("FAIL bp_first_latency: got %0d want 3", n + 1); end
    held = b2.rsp_rdata;
    vec++; if (held !== ea) begin bad++; $display("FAIL bp_first_data: got %h want %h", held, ea); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vec++; if ({b2.rsp_valid, b2.req_ready, b2.rsp_rdata} !== {2'b10, ea})
        begin bad++; $display("FAIL bp_hold_%0d: got vld=%b rdy=%b rd=%h want 1 0 %h",
                              c, b2.rsp_valid, b2.req_ready, b2.rsp_rdata, ea); end
    end
    b2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b2.rsp_ready = 1'b0;
    vec++; if ({b2.rsp_valid, b2.req_ready, b2.rsp_rdata} !== {2'b01, 32'd0})
      begin bad++; $display("FAIL bp_release: got vld=%b rdy=%b rd=%h want 0 1 0",
                            b2.rsp_valid, b2.req_ready, b2.rsp_rdata); end
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    n = 0;
    while (!b2.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    vec++; if ({n, b2.rsp_rdata} !== {32'd2, eb})
      begin bad++; $display("FAIL bp_second: got lat=%0d rd=%h want 3 %h", n + 1, b2.rsp_rdata, eb); end
    b2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b2.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, erd, e30; logic er, eer, e; int lat;
    model(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, e30, e);
    b2.req_valid = 1'b1; b2.req_we = 1'b1; b2.req_size = 2'd2; b2.req_unsigned = 1'b0;
    b2.req_addr = 32'h30; b2.req_wdata = 32'h55;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vec++; if ({b2.req_ready, b2.rsp_valid, b2.rsp_err, b2.rsp_rdata} !== {3'b100, 32'd0})
      begin bad++; $display("FAIL rst_mid_outputs: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0",
                            b2.req_ready, b2.rsp_valid, b2.rsp_err, b2.rsp_rdata); end
    run(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat, erd, eer);
    vec++; if ({er, rd} !== {1'b0, e30})
      begin bad++; $display("FAIL rst_mid_dropped: got err=%b rd=%h want 0 %h", er, rd, e30); end
  endtask

  task automatic test_random;
    logic [31:0] rd, erd, a; logic er, eer, we, uns; logic [1:0] sz; int lat;
    for (int i = 0; i < 300; i++) begin
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = 32'($urandom_range(0, 1023));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 15) == 0) a = a + 32'h400 + 32'($urandom_range(0, 4095));
      run(we, sz, uns, a, $urandom, rd, er, lat, erd, eer);
      vec++; if ({er, rd, lat} !== {eer, erd, 32'd3})
        begin bad++; $display("FAIL rand_%0d: we=%b sz=%0d a=%h got err=%b rd=%h lat=%0d want %b %h 3",
                              i, we, sz, a, er, rd, lat, eer, erd); end
    end
  endtask

  task automatic test_back_to_back_lat0;
    logic [31:0] erd; logic eer; op_t o;
    b0.req_valid = 1'b1;
    b0.rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      o.we  = (i < 8);
      o.sz  = (i < 16) ? 2'd2 : 2'($urandom_range(0, 1));
      o.uns = 1'($urandom);
      o.a   = 32'((i % 8) * 4 + ((i >= 16) ? 2 : 0));
      o.wd  = $urandom;
      b0.req_we = o.we; b0.req_size = o.sz; b0.req_unsigned = o.uns;
      b0.req_addr = o.a; b0.req_wdata = o.wd;
      model(1024, o.we, o.sz, o.uns, o.a, o.wd, erd, eer);
      vec++; if ({b0.req_ready, b0.rsp_valid} !== 2'b10)
        begin bad++; $display("FAIL lat0_idle_%0d: got rdy=%b vld=%b want 1 0", i, b0.req_ready, b0.rsp_valid); end
      @(posedge clk); #1;
      vec++; if ({b0.rsp_valid, b0.req_ready, b0.rsp_err, b0.rsp_rdata} !== {2'b10, eer, erd})
        begin bad++; $display("FAIL lat0_rsp_%0d: got vld=%b rdy=%b err=%b rd=%h want 1 0 %b %h",
                              i, b0.rsp_valid, b0.req_ready, b0.rsp_err, b0.rsp_rdata, eer, erd); end
      @(posedge clk); #1;
    end
    b0.req_valid = 1'b0;
    b0.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_preload();
    test_word_roundtrip();
    test_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back_lat0();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
